mix_columns_seq: RTL

- Iterative AES MixColumns / InvMixColumns engine for the 128-bit cipher state.
- Processes COLS_PER_CYCLE columns per clock, so one shared column datapath (xtime-based GF(2^8) arithmetic) is reused across the four columns.
- Sits between ShiftRows and AddRoundKey in the round pipeline, using a valid/ready handshake on both sides.
- The round controller selects forward or inverse operation per block.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/mix_single_column.sv | 51 +++++
 rtl/mix_columns_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, the MixColumns FSM encoding and the GF(2^8) xtime helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [7:0] aes_byte_t;
    // Element [3] is row 0, so a column packs MSB-first like the bus.
    typedef aes_byte_t [3:0] aes_col_t;
    // Element [3] is column 0, so a state packs MSB-first like the bus.
    typedef aes_col_t [3:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mcs_state_e;

    // Multiply by x in GF(2^8): shift left, fold the overflow back in.
    function automatic aes_byte_t gf_xtime(input aes_byte_t a, input aes_byte_t poly = AES_POLY);
        return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// One-column MixColumns / InvMixColumns transform built only from xtime and XOR.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mix_single_column
    import aes_pkg::*;
#(
    parameter logic [7:0] AES_POLY = aes_pkg::AES_POLY
) (
    input  aes_col_t col_in,
    input  logic     inverse,
    output aes_col_t col_out
);

    aes_byte_t a0, a1, a2, a3;
    aes_byte_t u, v;
    aes_byte_t p0, p1, p2, p3;
    aes_byte_t x0, x1, x2, x3;

    // Inverse preprocessing folds the 4x/x^2 terms in, then the shared forward equations run.
    always_comb begin
        a0 = col_in[3];
        a1 = col_in[2];
        a2 = col_in[1];
        a3 = col_in[0];

        u = gf_xtime(gf_xtime(a0 ^ a2, AES_POLY), AES_POLY);
        v = gf_xtime(gf_xtime(a1 ^ a3, AES_POLY), AES_POLY);

        p0 = a0;
        p1 = a1;
        p2 = a2;
        p3 = a3;
        if (inverse) begin
            p0 = a0 ^ u;
            p1 = a1 ^ v;
            p2 = a2 ^ u;
            p3 = a3 ^ v;
        end

        x0 = gf_xtime(p0, AES_POLY);
        x1 = gf_xtime(p1, AES_POLY);
        x2 = gf_xtime(p2, AES_POLY);
        x3 = gf_xtime(p3, AES_POLY);

        col_out[3] = x0 ^ x1 ^ p1 ^ p2 ^ p3;
        col_out[2] = p0 ^ x1 ^ x2 ^ p2 ^ p3;
        col_out[1] = p0 ^ p1 ^ x2 ^ x3 ^ p3;
        col_out[0] = x0 ^ p0 ^ p1 ^ p2 ^ x3;
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: COLS_PER_CYCLE columns transformed in place per clock.
// Latency: 4/COLS_PER_CYCLE cycles from accept to out_valid.
// Backpressure: result held stable in DONE until out_ready; no accept outside IDLE.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int         COLS_PER_CYCLE = 1,
    parameter logic [7:0] AES_POLY       = aes_pkg::AES_POLY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // With 4 columns per cycle the counter step is 0 and it simply stays at 0.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    mcs_state_e  state_q, state_d;
    aes_state_t  work_q, work_d;
    aes_state_t  out_q;
    logic [1:0]  col_cnt_q;
    logic        inv_q;
    logic        out_valid_q;
    logic        last_grp;

    logic [1:0]  grp_idx [COLS_PER_CYCLE];
    aes_col_t    grp_in  [COLS_PER_CYCLE];
    aes_col_t    grp_out [COLS_PER_CYCLE];

    // Column index g of this group; column c lives at packed element 3-c, i.e. ~c.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign grp_idx[g] = col_cnt_q + 2'(g);
        assign grp_in[g]  = work_q[~grp_idx[g]];

        mix_single_column #(
            .AES_POLY (AES_POLY)
        ) u_col (
            .col_in  (grp_in[g]),
            .inverse (inv_q),
            .col_out (grp_out[g])
        );
    end

    assign last_grp = (col_cnt_q == LAST);

    // Merge the freshly transformed columns back into the working state.
    always_comb begin
        work_d = work_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_d[~grp_idx[g]] = grp_out[g];
        end
    end

    // Next-state and input-side handshake decode.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_grp) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Working register, column counter, latched mode and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q      <= '0;
            out_q       <= '0;
            col_cnt_q   <= 2'd0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q    <= in_state;
                        inv_q     <= in_inverse;
                        col_cnt_q <= 2'd0;
                    end
                end
                RUN: begin
                    work_q    <= work_d;
                    col_cnt_q <= col_cnt_q + STEP;
                    if (last_grp) out_q <= work_d;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_q;
    assign busy      = (state_q != IDLE);

endmodule
